// File: rtl/mbu_pkg.sv
// Shared MBU definitions: address codes decoded by the MBU, debug opcodes,
// arbiter state encoding and the latched debug command.
package mbu_pkg;

  // MBU address codes; the MBU decoder uses the same values.
  localparam logic [4:0] MBU_MB     = 5'b11011;  // MBn via IR[2:0]
  localparam logic [4:0] MBU_C1C    = 5'b11100;
  localparam logic [4:0] MBU_C1D    = 5'b11101;
  localparam logic [4:0] MBU_CTX    = 5'b11110;
  localparam logic [2:0] MBU_AR_PFX = 3'b001;    // waddr[4:2] prefix for AR writes

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11   // behaves as a read
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_SAMPLE, ST_NEXT, ST_ACK
  } dbg_state_e;

  typedef struct packed {
    dbg_op_e    op;
    logic       ctx;    // target is CTX (sel >= 8)
    logic [7:0] wdata;
  } dbg_cmd_t;

  function automatic logic is_mbu_code(input logic [4:0] a);
    return (a == MBU_MB) || (a == MBU_C1C) || (a == MBU_C1D) || (a == MBU_CTX);
  endfunction

endpackage

// File: rtl/mbu_cu_detect.sv
// Combinational CU-activity decode: the CU is touching the MBU (or an AR
// write is in flight) whenever it presents one of the MBU codes.
//   cu_raddr, cu_waddr : CU address decoder outputs
//   cu_act             : CU owns the MBU this cycle
module mbu_cu_detect
  import mbu_pkg::*;
(
  input  logic [4:0] cu_raddr,
  input  logic [4:0] cu_waddr,
  output logic       cu_act
);

  assign cu_act = is_mbu_code(cu_raddr) | is_mbu_code(cu_waddr) |
                  (cu_waddr[4:2] == MBU_AR_PFX);

endmodule

// File: rtl/mbu_dbg_arbiter.sv
// MBU sequencer/arbiter between the CU and the debug requester.
// CU addresses pass through in IDLE; while halted and the CU is idle a debug
// request is granted and sequenced as SETUP -> STROBE (write) or
// SETUP -> SAMPLE (read/dump), with dumps walking MB0..MB7 through NEXT.
//   clk4/rsthold          : clock, synchronous active-high reset
//   halted                : debug grants allowed
//   cu_raddr/waddr/ir     : CU side; raddr/waddr/ir_sel : MBU side
//   dbg_req/op/sel/wdata  : debug request (level, held until dbg_ack)
//   dbg_rdata/rvalid/ack  : debug response pulses
//   ibus_in/out/oe        : IBUS sample and drive
//   busy                  : not IDLE
module mbu_dbg_arbiter
  import mbu_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned STB_CYC   = 2
) (
  input  logic       clk4,
  input  logic       rsthold,
  input  logic       halted,
  input  logic [4:0] cu_raddr,
  input  logic [4:0] cu_waddr,
  input  logic [2:0] cu_ir,
  output logic [4:0] raddr,
  output logic [4:0] waddr,
  output logic [2:0] ir_sel,
  input  logic       dbg_req,
  input  logic [1:0] dbg_op,
  input  logic [3:0] dbg_sel,
  input  logic [7:0] dbg_wdata,
  output logic [7:0] dbg_rdata,
  output logic       dbg_rvalid,
  output logic       dbg_ack,
  input  logic [7:0] ibus_in,
  output logic [7:0] ibus_out,
  output logic       ibus_oe,
  output logic       busy
);

  localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYC - 1);
  localparam logic [1:0] STB_LAST   = 2'(STB_CYC - 1);

  dbg_state_e state, state_nxt;
  dbg_cmd_t   cmd;
  logic [1:0] cyc, cyc_nxt;
  logic [2:0] idx, idx_nxt;
  logic       cu_act, grant, sample_last;
  logic       is_wr, is_dump;
  logic [4:0] code;

  mbu_cu_detect u_cu_detect (
    .cu_raddr (cu_raddr),
    .cu_waddr (cu_waddr),
    .cu_act   (cu_act)
  );

  assign is_wr   = (cmd.op == OP_WRITE);
  assign is_dump = (cmd.op == OP_DUMP);
  // A dump always walks MBn, whatever sel was.
  assign code    = (cmd.ctx && !is_dump) ? MBU_CTX : MBU_MB;

  always_ff @(posedge clk4) begin
    if (rsthold) begin
      state      <= ST_IDLE;
      cyc        <= '0;
      idx        <= '0;
      cmd        <= '{op: OP_READ, ctx: 1'b0, wdata: 8'h00};
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      idx        <= idx_nxt;
      dbg_rvalid <= sample_last;
      if (grant)
        cmd <= '{op: dbg_op_e'(dbg_op), ctx: dbg_sel[3], wdata: dbg_wdata};
      if (sample_last)
        dbg_rdata <= ibus_in;
    end
  end

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = '0;
    idx_nxt     = idx;
    grant       = 1'b0;
    sample_last = 1'b0;
    raddr       = '0;
    waddr       = '0;
    ir_sel      = idx;
    ibus_oe     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        raddr  = cu_raddr;
        waddr  = cu_waddr;
        ir_sel = cu_ir;
        // CU wins a same-cycle collision; the request just waits.
        if (dbg_req && halted && !cu_act) begin
          grant     = 1'b1;
          state_nxt = ST_SETUP;
          idx_nxt   = (dbg_op_e'(dbg_op) == OP_DUMP) ? 3'd0 : dbg_sel[2:0];
        end
      end
      ST_SETUP: begin
        // Write data goes on the bus first; waddr stays 00000 until STROBE.
        ibus_oe = is_wr;
        if (!is_wr) raddr = code;
        if (cyc == SETUP_LAST) state_nxt = is_wr ? ST_STROBE : ST_SAMPLE;
        else                   cyc_nxt   = cyc + 2'd1;
      end
      ST_STROBE: begin
        waddr   = code;
        ibus_oe = 1'b1;
        if (cyc == STB_LAST) state_nxt = ST_ACK;
        else                 cyc_nxt   = cyc + 2'd1;
      end
      ST_SAMPLE: begin
        raddr = code;
        if (cyc == STB_LAST) begin
          sample_last = 1'b1;
          state_nxt   = is_dump ? ST_NEXT : ST_ACK;
        end else begin
          cyc_nxt = cyc + 2'd1;
        end
      end
      ST_NEXT: begin
        if (idx == 3'd7) begin
          state_nxt = ST_ACK;
        end else begin
          idx_nxt   = idx + 3'd1;
          state_nxt = ST_SETUP;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_ack  = (state == ST_ACK);
  assign busy     = (state != ST_IDLE);
  assign ibus_out = ibus_oe ? cmd.wdata : 8'h00;

endmodule

// File: tb/tb_mbu_dbg_arbiter.sv
module tb_mbu_dbg_arbiter;

  logic       clk4 = 1'b0;
  logic       rsthold, halted;
  logic [4:0] cu_raddr, cu_waddr;
  logic [2:0] cu_ir;
  logic [4:0] raddr, waddr;
  logic [2:0] ir_sel;
  logic       dbg_req;
  logic [1:0] dbg_op;
  logic [3:0] dbg_sel;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       dbg_rvalid, dbg_ack;
  wire  [7:0] ibus_in;
  logic [7:0] ibus_out;
  logic       ibus_oe, busy;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural MBU: registers written on a strobe, read back onto IBUS.
  logic [7:0] mem [8];
  logic [7:0] ctx;
  assign ibus_in = (raddr == 5'b11011) ? mem[ir_sel] :
                   (raddr == 5'b11110) ? ctx : 8'hEE;
  always @(posedge clk4)
    if (!rsthold && ibus_oe) begin
      if (waddr == 5'b11011) mem[ir_sel] <= ibus_out;
      if (waddr == 5'b11110) ctx <= ibus_out;
    end

  always #5 clk4 = ~clk4;

  mbu_dbg_arbiter dut (
    .clk4(clk4), .rsthold(rsthold), .halted(halted),
    .cu_raddr(cu_raddr), .cu_waddr(cu_waddr), .cu_ir(cu_ir),
    .raddr(raddr), .waddr(waddr), .ir_sel(ir_sel),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_sel(dbg_sel), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_ack(dbg_ack),
    .ibus_in(ibus_in), .ibus_out(ibus_out), .ibus_oe(ibus_oe), .busy(busy)
  );

  // Observations from the last operation run through run_op.
  int         obs_lat, obs_oe, obs_wstb, obs_oe_first;
  logic [4:0] obs_wstb_addr, obs_raddr;
  logic [2:0] obs_wstb_ir;
  logic [7:0] obs_wdata;
  logic [7:0] rv_q [$];

  // Ref model state for the random test.
  logic [7:0] ref_mb [8];
  logic [7:0] ref_ctx;

  // Issue one request (called just after a negedge) and record what the bus
  // does until dbg_ack; obs_lat stays -1 if no ack within the bound.
  task automatic run_op(input logic [1:0] op, input logic [3:0] sel, input logic [7:0] wd);
    obs_lat = -1; obs_oe = 0; obs_wstb = 0; obs_oe_first = -1;
    obs_wstb_addr = 0; obs_wstb_ir = 0; obs_raddr = 0; obs_wdata = 0;
    rv_q.delete();
    dbg_req = 1'b1; dbg_op = op; dbg_sel = sel; dbg_wdata = wd;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk4);
      if (busy) begin
        if (ibus_oe) begin obs_oe++; obs_wdata = ibus_out; end
        if (waddr != 5'd0) begin
          obs_wstb++; obs_wstb_addr = waddr; obs_wstb_ir = ir_sel;
          if (obs_wstb == 1) obs_oe_first = obs_oe;
        end
        if (raddr != 5'd0) obs_raddr = raddr;
      end
      if (dbg_rvalid) rv_q.push_back(dbg_rdata);
      if (dbg_ack) begin obs_lat = c; break; end
    end
    dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    rsthold = 1'b1; halted = 1'b0; dbg_req = 1'b0; dbg_op = 2'b00; dbg_sel = 4'd0;
    dbg_wdata = 8'h00; cu_raddr = 5'h07; cu_waddr = 5'h00; cu_ir = 3'd2;
    repeat (3) @(negedge clk4);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", dbg_ack); end
    n_vec++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", dbg_rvalid); end
    n_vec++; if (dbg_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", dbg_rdata); end
    n_vec++; if (ibus_oe !== 1'b0 || ibus_out !== 8'h00) begin n_err++; $display("FAIL reset_ibus: got oe=%b out=%h want 0/00", ibus_oe, ibus_out); end
    n_vec++; if (raddr !== 5'h07 || ir_sel !== 3'd2) begin n_err++; $display("FAIL reset_passthru: got %h/%0d want 07/2", raddr, ir_sel); end
    rsthold = 1'b0; cu_raddr = 5'h00; cu_ir = 3'd0;
    @(negedge clk4);
  endtask

  task automatic test_passthrough();
    halted = 1'b0; dbg_req = 1'b1; dbg_op = 2'b00; dbg_sel = 4'd1;
    for (int i = 0; i < 4; i++) begin
      cu_raddr = 5'b11011; cu_ir = 3'd5; cu_waddr = 5'(i);
      #1;
      n_vec++; if (raddr !== 5'b11011 || ir_sel !== 3'd5 || waddr !== 5'(i)) begin
        n_err++; $display("FAIL passthru: got r=%b w=%b ir=%0d want 11011/%0d/5", raddr, waddr, ir_sel, i); end
      @(negedge clk4);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL passthru_busy: got %b want 0", busy); end
    end
    dbg_req = 1'b0; cu_raddr = 0; cu_waddr = 0; cu_ir = 0;
    @(negedge clk4);
  endtask

  task automatic test_single_write();
    halted = 1'b1;
    run_op(2'b01, 4'd3, 8'hA5);
    n_vec++; if (obs_lat !== 4) begin n_err++; $display("FAIL wr_latency: got %0d want 4", obs_lat); end
    n_vec++; if (obs_oe !== 3) begin n_err++; $display("FAIL wr_oe_cycles: got %0d want 3", obs_oe); end
    n_vec++; if (obs_wstb !== 2 || obs_oe_first !== 2) begin n_err++; $display("FAIL wr_strobe: got %0d cyc starting at oe %0d want 2/2", obs_wstb, obs_oe_first); end
    n_vec++; if (obs_wstb_addr !== 5'b11011 || obs_wstb_ir !== 3'd3 || obs_wdata !== 8'hA5) begin
      n_err++; $display("FAIL wr_addr: got %b/%0d/%h want 11011/3/a5", obs_wstb_addr, obs_wstb_ir, obs_wdata); end
    @(negedge clk4);
    n_vec++; if (mem[3] !== 8'hA5) begin n_err++; $display("FAIL wr_mem: got %h want a5", mem[3]); end
    n_vec++; if (rv_q.size() !== 0 || ibus_oe !== 1'b0) begin n_err++; $display("FAIL wr_after: got rv=%0d oe=%b want 0/0", rv_q.size(), ibus_oe); end
  endtask

  task automatic test_ctx_read();
    ctx = 8'h42;
    run_op(2'b00, 4'd8, 8'h00);
    n_vec++; if (obs_lat !== 4) begin n_err++; $display("FAIL ctxrd_latency: got %0d want 4", obs_lat); end
    n_vec++; if (obs_raddr !== 5'b11110) begin n_err++; $display("FAIL ctxrd_raddr: got %b want 11110", obs_raddr); end
    n_vec++; if (rv_q.size() !== 1) begin n_err++; $display("FAIL ctxrd_pulses: got %0d want 1", rv_q.size()); end
    else begin
      n_vec++; if (rv_q[0] !== 8'h42) begin n_err++; $display("FAIL ctxrd_data: got %h want 42", rv_q[0]); end
    end
    n_vec++; if (obs_oe !== 0 || obs_wstb !== 0) begin n_err++; $display("FAIL ctxrd_nowrite: got oe=%0d wstb=%0d want 0/0", obs_oe, obs_wstb); end
    @(negedge clk4);
  endtask

  task automatic test_dump();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    run_op(2'b10, 4'd5, 8'h00);
    n_vec++; if (obs_lat !== 33) begin n_err++; $display("FAIL dump_latency: got %0d want 33", obs_lat); end
    n_vec++; if (rv_q.size() !== 8) begin n_err++; $display("FAIL dump_pulses: got %0d want 8", rv_q.size()); end
    for (int i = 0; i < rv_q.size() && i < 8; i++) begin
      n_vec++; if (rv_q[i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL dump_data[%0d]: got %h want %h", i, rv_q[i], 8'h10 + 8'(i)); end
    end
    @(negedge clk4);
  endtask

  task automatic test_collision();
    logic [4:0] codes [4];
    codes[0] = 5'b11011; codes[1] = 5'b11100; codes[2] = 5'b11101; codes[3] = 5'b11110;
    halted = 1'b1; dbg_req = 1'b1; dbg_op = 2'b00; dbg_sel = 4'd1;
    for (int k = 0; k < 9; k++) begin
      int seen;
      cu_raddr = (k < 4) ? codes[k] : 5'd0;
      cu_waddr = (k >= 4 && k < 8) ? codes[k-4] : (k == 8) ? 5'b00101 : 5'd0;
      seen = 0;
      repeat (3) begin @(negedge clk4); if (busy) seen++; end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL collision_hold[%0d]: got %0d busy cycles want 0", k, seen); end
    end
    cu_raddr = 0; cu_waddr = 0;
    mem[1] = 8'h6B;
    run_op(2'b00, 4'd1, 8'h00);
    n_vec++; if (obs_lat !== 4 || rv_q.size() !== 1) begin n_err++; $display("FAIL collision_grant: got lat=%0d rv=%0d want 4/1", obs_lat, rv_q.size()); end
    else begin
      n_vec++; if (rv_q[0] !== 8'h6B) begin n_err++; $display("FAIL collision_data: got %h want 6b", rv_q[0]); end
    end
    @(negedge clk4);
  endtask

  task automatic test_random();
    halted = 1'b1;
    for (int i = 0; i < 8; i++) begin ref_mb[i] = 8'($urandom); mem[i] = ref_mb[i]; end
    ref_ctx = 8'($urandom); ctx = ref_ctx;
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op; logic [3:0] sel; logic [7:0] wd, ev;
      int exp_lat, exp_n;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10 && $urandom_range(0, 3) != 0) op = 2'b00;  // keep dumps rare
      sel = 4'($urandom); wd = 8'($urandom);
      run_op(op, sel, wd);
      exp_lat = (op == 2'b10) ? 33 : 4;
      exp_n   = (op == 2'b10) ? 8 : (op == 2'b01) ? 0 : 1;
      n_vec++; if (obs_lat !== exp_lat || rv_q.size() !== exp_n) begin
        n_err++; $display("FAIL rand[%0d] op=%0d sel=%0d: got lat=%0d rv=%0d want %0d/%0d", t, op, sel, obs_lat, rv_q.size(), exp_lat, exp_n); end
      else begin
        for (int j = 0; j < exp_n; j++) begin
          ev = (op == 2'b10) ? ref_mb[j] : (sel >= 4'd8) ? ref_ctx : ref_mb[sel[2:0]];
          n_vec++; if (rv_q[j] !== ev) begin n_err++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", t, j, rv_q[j], ev); end
        end
      end
      if (op == 2'b01) begin
        if (sel >= 4'd8) ref_ctx = wd; else ref_mb[sel[2:0]] = wd;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk4);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (mem[i] !== ref_mb[i]) begin n_err++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem[i], ref_mb[i]); end
    end
    n_vec++; if (ctx !== ref_ctx) begin n_err++; $display("FAIL rand_ctx: got %h want %h", ctx, ref_ctx); end
  endtask

  task automatic test_back_to_back();
    int lat2;
    halted = 1'b1; mem[2] = 8'h5E;
    dbg_req = 1'b1; dbg_op = 2'b00; dbg_sel = 4'd2;
    for (int c = 0; c < 20 && !dbg_ack; c++) @(negedge clk4);
    n_vec++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h5E) begin n_err++; $display("FAIL b2b_first: got ack=%b data=%h want 1/5e", dbg_ack, dbg_rdata); end
    dbg_op = 2'b01; dbg_sel = 4'd6; dbg_wdata = 8'h3C;   // request stays high
    halted = 1'b1;
    @(negedge clk4);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got busy=%b want 0", busy); end
    @(negedge clk4);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_regrant: got busy=%b want 1", busy); end
    halted = 1'b0;  // dropping halted must not abort the granted write
    lat2 = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk4);
      if (dbg_ack) begin lat2 = c; break; end
    end
    dbg_req = 1'b0;
    n_vec++; if (lat2 !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat2); end
    @(negedge clk4);
    n_vec++; if (mem[6] !== 8'h3C) begin n_err++; $display("FAIL b2b_mem: got %h want 3c", mem[6]); end
  endtask

  task automatic test_reset_mid_dump();
    int acks, busies;
    halted = 1'b1; acks = 0;
    dbg_req = 1'b1; dbg_op = 2'b10; dbg_sel = 4'd0;
    for (int c = 1; c <= 17; c++) begin @(negedge clk4); if (dbg_ack) acks++; end
    n_vec++; if (busy !== 1'b1 || ir_sel !== 3'd4) begin n_err++; $display("FAIL rstdump_idx: got busy=%b idx=%0d want 1/4", busy, ir_sel); end
    rsthold = 1'b1; dbg_req = 1'b0;
    @(negedge clk4);
    n_vec++; if (busy !== 1'b0 || dbg_ack !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rstdump_state: got busy=%b ack=%b rv=%b want 0/0/0", busy, dbg_ack, dbg_rvalid); end
    n_vec++; if (dbg_rdata !== 8'h00 || ibus_oe !== 1'b0 || ibus_out !== 8'h00) begin
      n_err++; $display("FAIL rstdump_regs: got rdata=%h oe=%b out=%h want 00/0/00", dbg_rdata, ibus_oe, ibus_out); end
    rsthold = 1'b0; busies = 0;
    repeat (40) begin @(negedge clk4); if (dbg_ack) acks++; if (busy) busies++; end
    n_vec++; if (acks !== 0 || busies !== 0) begin n_err++; $display("FAIL rstdump_quiet: got acks=%0d busy=%0d want 0/0", acks, busies); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single_write();
    test_ctx_read();
    test_dump();
    test_collision();
    test_random();
    test_back_to_back();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
